// File: rtl/noc_link_pipe.sv
// noc_link_pipe: pipelined point-to-point NoC link.
// Flits travel downstream and credits travel upstream through NUM_PIPELINE
// register stages each. The link also tracks the upstream sender's credits,
// whether a packet is currently open, and sticky credit protocol errors.
module noc_link_pipe #(
    parameter int FLIT_WIDTH        = 128,
    parameter int DEST_WIDTH        = 6,
    parameter int NUM_PIPELINE      = 1,
    parameter int FLIT_BUFFER_DEPTH = 8,
    localparam int CNT_WIDTH        = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                  clk_noc,
    input  logic                  rst_n,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    output logic                  send_out,
    input  logic                  credit_in,
    output logic [CNT_WIDTH-1:0]  credits_avail,
    output logic                  pkt_open,
    output logic                  err_underflow,
    output logic                  err_overflow
);

    localparam logic [CNT_WIDTH-1:0] MAX_CREDITS = CNT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CNT_WIDTH-1:0] ONE_CREDIT  = CNT_WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } pkt_state_t;

    logic [CNT_WIDTH-1:0] r_creditCount;
    logic                 r_errUnderflow;
    logic                 r_errOverflow;
    pkt_state_t           r_pktState;
    pkt_state_t           w_pktStateNext;

    generate
        if (NUM_PIPELINE == 0) begin : g_bypass
            assign data_out    = data_in;
            assign dest_out    = dest_in;
            assign is_tail_out = is_tail_in;
            assign send_out    = send_in;
            assign credit_out  = credit_in;
        end else begin : g_pipe
            logic [FLIT_WIDTH-1:0] r_data   [NUM_PIPELINE];
            logic [DEST_WIDTH-1:0] r_dest   [NUM_PIPELINE];
            logic                  r_tail   [NUM_PIPELINE];
            logic                  r_send   [NUM_PIPELINE];
            logic                  r_credit [NUM_PIPELINE];

            // Shift flits downstream and credits upstream; payload stages only load behind a valid flit.
            always_ff @(posedge clk_noc or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < NUM_PIPELINE; i++) begin
                        r_data[i]   <= '0;
                        r_dest[i]   <= '0;
                        r_tail[i]   <= 1'b0;
                        r_send[i]   <= 1'b0;
                        r_credit[i] <= 1'b0;
                    end
                end else begin
                    r_send[0]   <= send_in;
                    r_credit[0] <= credit_in;
                    if (send_in) begin
                        r_data[0] <= data_in;
                        r_dest[0] <= dest_in;
                        r_tail[0] <= is_tail_in;
                    end
                    for (int i = 1; i < NUM_PIPELINE; i++) begin
                        r_send[i]   <= r_send[i-1];
                        r_credit[i] <= r_credit[i-1];
                        if (r_send[i-1]) begin
                            r_data[i] <= r_data[i-1];
                            r_dest[i] <= r_dest[i-1];
                            r_tail[i] <= r_tail[i-1];
                        end
                    end
                end
            end

            assign data_out    = r_data[NUM_PIPELINE-1];
            assign dest_out    = r_dest[NUM_PIPELINE-1];
            assign is_tail_out = r_tail[NUM_PIPELINE-1];
            assign send_out    = r_send[NUM_PIPELINE-1];
            assign credit_out  = r_credit[NUM_PIPELINE-1];
        end
    endgenerate

    // Mirror the upstream sender's credit count, clamping at the ends and latching any protocol error.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_creditCount  <= MAX_CREDITS;
            r_errUnderflow <= 1'b0;
            r_errOverflow  <= 1'b0;
        end else begin
            case ({send_in, credit_out})
                2'b10: begin
                    if (r_creditCount == '0) begin
                        r_errUnderflow <= 1'b1;
                    end else begin
                        r_creditCount <= r_creditCount - ONE_CREDIT;
                    end
                end
                2'b01: begin
                    if (r_creditCount == MAX_CREDITS) begin
                        r_errOverflow <= 1'b1;
                    end else begin
                        r_creditCount <= r_creditCount + ONE_CREDIT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Packet tracker state register.
    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            r_pktState <= IDLE;
        end else begin
            r_pktState <= w_pktStateNext;
        end
    end

    // A non-tail flit opens a packet, a tail flit closes it; single-flit packets never open.
    always_comb begin
        w_pktStateNext = r_pktState;
        case (r_pktState)
            IDLE: begin
                if (send_in && !is_tail_in) begin
                    w_pktStateNext = OPEN;
                end
            end
            OPEN: begin
                if (send_in && is_tail_in) begin
                    w_pktStateNext = IDLE;
                end
            end
            default: begin
                w_pktStateNext = IDLE;
            end
        endcase
    end

    assign credits_avail = r_creditCount;
    assign pkt_open      = (r_pktState == OPEN);
    assign err_underflow = r_errUnderflow;
    assign err_overflow  = r_errOverflow;

endmodule

// File: tb/tb_noc_link_pipe.sv
// tb_noc_link_pipe: drives a combinational (NUM_PIPELINE=0) and a two-stage
// (NUM_PIPELINE=2) link with the same upstream traffic and scores both
// against a cycle-level reference model of the link's rules.
module tb_noc_link_pipe;

    localparam int FW    = 128;
    localparam int DW    = 6;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    typedef struct packed {
        logic [FW-1:0] data;
        logic [DW-1:0] dest;
        logic          tail;
        int            due;
    } flit_t;

    logic          clk_noc = 1'b0;
    logic          rst_n   = 1'b0;
    logic [FW-1:0] data_in;
    logic [DW-1:0] dest_in;
    logic          is_tail_in;
    logic          send_in;
    logic          credit_in;

    logic [FW-1:0] data_out0, data_out2;
    logic [DW-1:0] dest_out0, dest_out2;
    logic          is_tail_out0, is_tail_out2;
    logic          send_out0, send_out2;
    logic          credit_out0, credit_out2;
    logic [CW-1:0] credits_avail0, credits_avail2;
    logic          pkt_open0, pkt_open2;
    logic          err_underflow0, err_underflow2;
    logic          err_overflow0, err_overflow2;

    flit_t flitQ [2][$];
    bit    credHist [0:8191];
    int    cyc       = 0;
    int    lastReset = -1;
    int    checks    = 0;
    int    failures  = 0;
    int    mCredits [2];
    bit    mUnder [2];
    bit    mOver [2];
    bit    mOpen;

    always #5 clk_noc = ~clk_noc;

    noc_link_pipe #(
        .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(0), .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut0 (
        .clk_noc(clk_noc), .rst_n(rst_n),
        .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
        .credit_out(credit_out0),
        .data_out(data_out0), .dest_out(dest_out0), .is_tail_out(is_tail_out0), .send_out(send_out0),
        .credit_in(credit_in),
        .credits_avail(credits_avail0), .pkt_open(pkt_open0),
        .err_underflow(err_underflow0), .err_overflow(err_overflow0)
    );

    noc_link_pipe #(
        .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .NUM_PIPELINE(2), .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut2 (
        .clk_noc(clk_noc), .rst_n(rst_n),
        .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
        .credit_out(credit_out2),
        .data_out(data_out2), .dest_out(dest_out2), .is_tail_out(is_tail_out2), .send_out(send_out2),
        .credit_in(credit_in),
        .credits_avail(credits_avail2), .pkt_open(pkt_open2),
        .err_underflow(err_underflow2), .err_overflow(err_overflow2)
    );

    function automatic int npOf(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    // A credit reaches credit_out NUM_PIPELINE cycles after it was offered, unless a reset came in between.
    function automatic bit expCredOut(input int k, input int c);
        int src;
        src = c - npOf(k);
        if (src < 0 || src <= lastReset) return 1'b0;
        return credHist[src];
    endfunction

    function automatic logic [FW-1:0] randFlit();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string name, input int k, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s inst_np%0d cycle %0d: got %0h expected %0h", name, npOf(k), cyc, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mCredits[k] = DEPTH;
            mUnder[k]   = 1'b0;
            mOver[k]    = 1'b0;
            flitQ[k].delete();
        end
        mOpen     = 1'b0;
        lastReset = cyc;
    endtask

    // One upstream cycle: drive the inputs and record what each link owes downstream.
    task automatic applyStimulus(input bit s, input logic [FW-1:0] d, input logic [DW-1:0] de,
                                 input bit t, input bit cr);
        flit_t f;
        @(posedge clk_noc);
        #1;
        send_in    = s;
        data_in    = d;
        dest_in    = de;
        is_tail_in = t;
        credit_in  = cr;
        credHist[cyc] = cr;
        if (s) begin
            for (int k = 0; k < 2; k++) begin
                f.data = d;
                f.dest = de;
                f.tail = t;
                f.due  = cyc + npOf(k);
                flitQ[k].push_back(f);
            end
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Assert reset mid-cycle, confirm the immediate clear, then release after two edges.
    task automatic doReset();
        @(posedge clk_noc);
        #1;
        rst_n      = 1'b0;
        send_in    = 1'b0;
        credit_in  = 1'b0;
        is_tail_in = 1'b0;
        modelReset();
        #1;
        checkOutput("send_out_in_reset", 1, FW'(send_out2), FW'(0));
        checkOutput("credits_in_reset", 1, FW'(credits_avail2), FW'(DEPTH));
        checkOutput("credits_in_reset", 0, FW'(credits_avail0), FW'(DEPTH));
        repeat (2) @(posedge clk_noc);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model: advance credit count, error flags and packet state at each clock edge.
    always @(posedge clk_noc) begin
        if (!rst_n) begin
            modelReset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit co;
                co = expCredOut(k, cyc);
                if (send_in && !co) begin
                    if (mCredits[k] == 0) mUnder[k] = 1'b1;
                    else mCredits[k] = mCredits[k] - 1;
                end else if (!send_in && co) begin
                    if (mCredits[k] == DEPTH) mOver[k] = 1'b1;
                    else mCredits[k] = mCredits[k] + 1;
                end
            end
            if (send_in) mOpen = !is_tail_in;
        end
        cyc++;
    end

    // Monitor: score every flit the links present and compare the status outputs each cycle.
    always @(negedge clk_noc) begin
        logic [FW-1:0] dOut [2];
        logic [DW-1:0] deOut [2];
        logic          tOut [2];
        logic          sOut [2];
        logic          cOut [2];
        logic [CW-1:0] crOut [2];
        logic          oOut [2];
        logic          uOut [2];
        logic          vOut [2];
        flit_t         f;
        dOut[0] = data_out0;      dOut[1] = data_out2;
        deOut[0] = dest_out0;     deOut[1] = dest_out2;
        tOut[0] = is_tail_out0;   tOut[1] = is_tail_out2;
        sOut[0] = send_out0;      sOut[1] = send_out2;
        cOut[0] = credit_out0;    cOut[1] = credit_out2;
        crOut[0] = credits_avail0; crOut[1] = credits_avail2;
        oOut[0] = pkt_open0;      oOut[1] = pkt_open2;
        uOut[0] = err_underflow0; uOut[1] = err_underflow2;
        vOut[0] = err_overflow0;  vOut[1] = err_overflow2;
        for (int k = 0; k < 2; k++) begin
            while (flitQ[k].size() > 0 && flitQ[k][0].due < cyc) begin
                checks++;
                failures++;
                $display("[TB] FAIL missing_flit inst_np%0d cycle %0d: got no send_out, required flit due at cycle %0d",
                         npOf(k), cyc, flitQ[k][0].due);
                void'(flitQ[k].pop_front());
            end
            if (sOut[k]) begin
                if (flitQ[k].size() == 0 || flitQ[k][0].due != cyc) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_flit inst_np%0d cycle %0d: got send_out=1 data %0h, required send_out=0",
                             npOf(k), cyc, dOut[k]);
                end else begin
                    f = flitQ[k].pop_front();
                    checkOutput("data_out", k, dOut[k], f.data);
                    checkOutput("dest_out", k, FW'(deOut[k]), FW'(f.dest));
                    checkOutput("is_tail_out", k, FW'(tOut[k]), FW'(f.tail));
                end
            end
            checkOutput("credit_out", k, FW'(cOut[k]), FW'(expCredOut(k, cyc)));
            checkOutput("credits_avail", k, FW'(crOut[k]), FW'(mCredits[k]));
            checkOutput("pkt_open", k, FW'(oOut[k]), FW'(mOpen));
            checkOutput("err_underflow", k, FW'(uOut[k]), FW'(mUnder[k]));
            checkOutput("err_overflow", k, FW'(vOut[k]), FW'(mOver[k]));
        end
    end

    // Directed scenarios first, then randomized traffic, then a reset with flits in flight.
    initial begin
        logic [FW-1:0] a5;
        a5         = FW'(8'hA5);
        data_in    = '0;
        dest_in    = '0;
        is_tail_in = 1'b0;
        send_in    = 1'b0;
        credit_in  = 1'b0;
        modelReset();
        repeat (3) @(posedge clk_noc);
        #1;
        rst_n = 1'b1;
        checkOutput("reset_credits", 1, FW'(credits_avail2), FW'(DEPTH));
        checkOutput("reset_pkt_open", 1, FW'(pkt_open2), FW'(0));
        checkOutput("reset_err_underflow", 1, FW'(err_underflow2), FW'(0));

        // Latency of the two-stage link and same-cycle pass-through of the bypass link.
        applyStimulus(1'b1, a5, 6'h3, 1'b1, 1'b0);
        @(negedge clk_noc);
        checkOutput("lat_cycle0_send", 1, FW'(send_out2), FW'(0));
        checkOutput("bypass_data", 0, data_out0, a5);
        checkOutput("bypass_send", 0, FW'(send_out0), FW'(1));
        idle();
        @(negedge clk_noc);
        checkOutput("lat_cycle1_send", 1, FW'(send_out2), FW'(0));
        idle();
        @(negedge clk_noc);
        checkOutput("lat_cycle2_send", 1, FW'(send_out2), FW'(1));
        checkOutput("lat_cycle2_data", 1, data_out2, a5);
        idle();
        @(negedge clk_noc);
        checkOutput("lat_cycle3_send", 1, FW'(send_out2), FW'(0));
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        @(negedge clk_noc);
        checkOutput("bypass_credit", 0, FW'(credit_out0), FW'(1));
        repeat (3) idle();

        // Drain all credits, then one send too many.
        doReset();
        repeat (8) applyStimulus(1'b1, randFlit(), DW'($urandom), 1'b0, 1'b0);
        idle();
        @(negedge clk_noc);
        checkOutput("drained_credits", 0, FW'(credits_avail0), FW'(0));
        checkOutput("drained_credits", 1, FW'(credits_avail2), FW'(0));
        checkOutput("drained_no_underflow", 1, FW'(err_underflow2), FW'(0));
        checkOutput("long_pkt_open", 1, FW'(pkt_open2), FW'(1));
        applyStimulus(1'b1, randFlit(), DW'($urandom), 1'b1, 1'b0);
        idle();
        @(negedge clk_noc);
        checkOutput("underflow_credits", 0, FW'(credits_avail0), FW'(0));
        checkOutput("underflow_flag", 0, FW'(err_underflow0), FW'(1));
        checkOutput("underflow_credits", 1, FW'(credits_avail2), FW'(0));
        checkOutput("underflow_flag", 1, FW'(err_underflow2), FW'(1));
        repeat (2) idle();

        // Extra credit at full count, then down to 5 and a send paired with a credit.
        doReset();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (3) idle();
        @(negedge clk_noc);
        checkOutput("overflow_flag", 0, FW'(err_overflow0), FW'(1));
        checkOutput("overflow_flag", 1, FW'(err_overflow2), FW'(1));
        checkOutput("overflow_credits", 1, FW'(credits_avail2), FW'(DEPTH));
        repeat (3) applyStimulus(1'b1, randFlit(), DW'($urandom), 1'b1, 1'b0);
        applyStimulus(1'b1, randFlit(), DW'($urandom), 1'b1, 1'b1);
        repeat (3) idle();
        @(negedge clk_noc);
        checkOutput("hold_at_5", 0, FW'(credits_avail0), FW'(5));
        checkOutput("hold_at_5", 1, FW'(credits_avail2), FW'(5));
        checkOutput("overflow_sticky", 1, FW'(err_overflow2), FW'(1));

        // Three-flit packet then a single-flit packet.
        doReset();
        applyStimulus(1'b1, randFlit(), 6'h11, 1'b0, 1'b0);
        @(negedge clk_noc);
        checkOutput("pkt_before_first", 1, FW'(pkt_open2), FW'(0));
        applyStimulus(1'b1, randFlit(), 6'h11, 1'b0, 1'b0);
        @(negedge clk_noc);
        checkOutput("pkt_after_first", 1, FW'(pkt_open2), FW'(1));
        applyStimulus(1'b1, randFlit(), 6'h11, 1'b1, 1'b0);
        @(negedge clk_noc);
        checkOutput("pkt_after_second", 0, FW'(pkt_open0), FW'(1));
        idle();
        @(negedge clk_noc);
        checkOutput("pkt_after_tail", 1, FW'(pkt_open2), FW'(0));
        applyStimulus(1'b1, randFlit(), 6'h22, 1'b1, 1'b0);
        idle();
        @(negedge clk_noc);
        checkOutput("single_flit_pkt", 1, FW'(pkt_open2), FW'(0));
        repeat (3) idle();

        // Randomized traffic and credits.
        doReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), randFlit(), DW'($urandom),
                          ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)));
        end
        repeat (3) idle();

        // Reset with two flits in the two-stage pipe; nothing stale may emerge afterwards.
        applyStimulus(1'b1, randFlit(), DW'($urandom), 1'b0, 1'b1);
        applyStimulus(1'b1, randFlit(), DW'($urandom), 1'b0, 1'b1);
        doReset();
        repeat (6) idle();

        for (int k = 0; k < 2; k++) begin
            checkOutput("scoreboard_empty", k, FW'(flitQ[k].size()), FW'(0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_link_pipe.md
NOC_LINK_PIPE -- requirements
Module: noc_link_pipe

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 128: flit payload width in bits.
REQ-002 SHALL have parameter DEST_WIDTH, default 6: destination field width (tdest plus tid).
REQ-003 SHALL have parameter NUM_PIPELINE, default 1, legal 0..4: register stages in each direction.
REQ-004 SHALL have parameter FLIT_BUFFER_DEPTH, default 8: downstream input buffer depth, which is the initial credit count.
REQ-005 SHALL have localparam CNT_WIDTH = $clog2(FLIT_BUFFER_DEPTH+1).
REQ-006 SHALL have port clk_noc, input, 1: the single clock for all logic.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port data_in, input, FLIT_WIDTH: flit from the upstream router.
REQ-009 SHALL have port dest_in, input, DEST_WIDTH: flit destination.
REQ-010 SHALL have port is_tail_in, input, 1: last flit of the packet.
REQ-011 SHALL have port send_in, input, 1: flit valid this cycle.
REQ-012 SHALL have port credit_out, output, 1: credit returned to the upstream router.
REQ-013 SHALL have ports data_out, dest_out, is_tail_out and send_out, outputs, widths matching their _in ports: flit toward the downstream router.
REQ-014 SHALL have port credit_in, input, 1: credit from the downstream router.
REQ-015 SHALL have port credits_avail, output, CNT_WIDTH: credits currently held by the upstream sender.
REQ-016 SHALL have port pkt_open, output, 1: a packet has started on the upstream side and its tail has not yet passed.
REQ-017 SHALL have ports err_underflow and err_overflow, outputs, 1 each: sticky protocol-error flags.

Function
REQ-018 Forward path SHALL delay {data, dest, is_tail, send} by exactly NUM_PIPELINE clk_noc cycles; with NUM_PIPELINE=0 it SHALL be a combinational pass-through.
REQ-019 Reverse path SHALL delay credit_in to credit_out by exactly NUM_PIPELINE cycles; with NUM_PIPELINE=0 it SHALL be a combinational pass-through.
REQ-020 Data, dest and is_tail stages SHALL load only when the matching send stage input is 1 and SHALL hold otherwise.
REQ-021 The send and credit stages SHALL load every cycle, so there are no bubbles and no backpressure.
REQ-022 credits_avail SHALL be a register observing the upstream side only (send_in, credit_out):
  - send_in=1, credit_out=0: decrement.
  - send_in=0, credit_out=1: increment.
  - both 1 or both 0: hold.
REQ-023 On send_in=1 with credits_avail=0 and credit_out=0, the counter SHALL stay at 0 and err_underflow SHALL set.
REQ-024 On credit_out=1 with credits_avail=FLIT_BUFFER_DEPTH and send_in=0, the counter SHALL stay at FLIT_BUFFER_DEPTH and err_overflow SHALL set.
REQ-025 Error flags SHALL be sticky until reset; the flit itself SHALL still be forwarded.
REQ-026 pkt_open SHALL use two states, IDLE(0) and OPEN(1):
  - IDLE->OPEN on send_in=1 with is_tail_in=0.
  - OPEN->IDLE on send_in=1 with is_tail_in=1.
  - Single-flit packets (send_in=1, is_tail_in=1 while IDLE) SHALL remain IDLE.
REQ-027 credits_avail, pkt_open and the error flags SHALL update on the clk_noc edge following the qualifying inputs (1-cycle latency).
REQ-028 Round-trip credit latency SHALL be 2*NUM_PIPELINE cycles plus downstream turnaround; FLIT_BUFFER_DEPTH must cover it, and this is the integrator's responsibility.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously clear all send and credit stages, data/dest/is_tail stages, pkt_open, err_underflow and err_overflow to 0, and set credits_avail to FLIT_BUFFER_DEPTH.
REQ-030 Reset asserted mid-packet SHALL discard in-flight flits and credits, with no send_out or credit_out pulse in the first cycle after deassertion unless driven combinationally (NUM_PIPELINE=0).
REQ-031 Reset deassertion SHALL be synchronous to clk_noc upstream of this block, and the block SHALL add no synchronizer.

Verification
REQ-032 With NUM_PIPELINE=2, send_in=1 and data_in=0xA5 at cycle 0 SHALL give send_out=1, data_out=0xA5 at cycle 2, and send_out=0 at cycles 1 and 3.
REQ-033 With NUM_PIPELINE=0, data_in, send_in and credit_in SHALL appear on data_out, send_out and credit_out in the same cycle.
REQ-034 Eight consecutive sends with no credits SHALL take credits_avail 8->0; a ninth send SHALL keep it at 0 and set err_underflow=1.
REQ-035 From credits_avail=8, a credit_out pulse with no send SHALL keep it at 8 and set err_overflow=1; simultaneous send and credit at 5 SHALL hold it at 5.
REQ-036 A 3-flit packet (tail on the third) SHALL give pkt_open 0->1 after flit 1 and 1->0 after flit 3; a single-flit packet SHALL keep pkt_open=0.
REQ-037 Asserting rst_n=0 with two flits in the NUM_PIPELINE=2 pipe SHALL give send_out=0 immediately, credits_avail=8, and no stale flit after release.
